// File: rtl/sram_req_arbiter.sv
// Two-master arbiter onto one SRAM-like request/response channel.
// Fetch and EX-stage requests share the bridge; a grant is held until the
// bridge accepts it, and a small owner FIFO steers in-order responses back.
module sram_req_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int PTR_W     = 2
) (
  input  logic        clk,
  input  logic        reset,
  // fetch side
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // EX-stage side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared channel toward the bridge
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTST);

  state_t                 state_q, state_d;
  logic                   pri_inst_q, pri_inst_d;
  logic                   resp_err_q, resp_err_d;
  logic [MAX_OUTST-1:0]   owner_q, owner_d;     // 0 = inst, 1 = data
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;

  logic sel_inst, sel_data;
  logic full, empty, accept, pop, head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = owner_q[rd_ptr_q];

  // Pick the requester: a lock pins the previous choice, otherwise data wins
  // unless fetch has been made to wait behind a data transfer already.
  always_comb begin
    sel_inst = 1'b0;
    sel_data = 1'b0;
    case (state_q)
      LOCK_I:  sel_inst = 1'b1;
      LOCK_D:  sel_data = 1'b1;
      default: begin
        if (data_req & ~(pri_inst_q & inst_req)) sel_data = 1'b1;
        else if (inst_req)                       sel_inst = 1'b1;
      end
    endcase
  end

  // Drive the shared channel; payload defaults to the data side when idle.
  always_comb begin
    mem_req   = ((sel_inst & inst_req) | (sel_data & data_req)) & ~full & ~reset;
    mem_wr    = sel_inst ? inst_wr    : data_wr;
    mem_size  = sel_inst ? inst_size  : data_size;
    mem_wstrb = sel_inst ? inst_wstrb : data_wstrb;
    mem_addr  = sel_inst ? inst_addr  : data_addr;
    mem_wdata = sel_inst ? inst_wdata : data_wdata;
  end

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & sel_inst;
  assign data_addr_ok = accept & sel_data;

  // Responses return in order; the FIFO head names the owner.
  assign pop          = mem_data_ok & ~empty;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign resp_err     = resp_err_q;

  // Grant lock: an offered but unaccepted request keeps its owner until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req & ~mem_addr_ok) state_d = sel_inst ? LOCK_I : LOCK_D;
      LOCK_I,
      LOCK_D:  if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fairness flag, owner FIFO bookkeeping and sticky orphan-response error.
  always_comb begin
    pri_inst_d = pri_inst_q;
    if (accept & sel_data & inst_req) pri_inst_d = 1'b1;
    if (accept & sel_inst)            pri_inst_d = 1'b0;

    owner_d = owner_q;
    if (accept) owner_d[wr_ptr_q] = sel_data;
    wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);

    resp_err_d = resp_err_q | (mem_data_ok & empty);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pri_inst_q <= 1'b0;
      resp_err_q <= 1'b0;
      owner_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pri_inst_q <= pri_inst_d;
      resp_err_q <= resp_err_d;
      owner_q    <= owner_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked each cycle against a queue-based model.
module tb_sram_req_arbiter;

  logic        clk = 1'b0, reset = 1'b1;
  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [3:0]  inst_wstrb = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [3:0]  data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  logic        resp_err;

  sram_req_arbiter #(.MAX_OUTST(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // model state: pending grant owner (0 none, 1 inst, 2 data), fairness, error, owners
  int lock = 0;
  bit pri = 0, err = 0;
  bit owners[$];
  bit last_iok = 0, last_dok = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    lock = 0; pri = 0; err = 0; owners.delete();
  endtask

  // Compare all outputs against the model for the current inputs, then
  // advance the model to its post-edge state.
  task automatic eval();
    int sel;
    bit e_req, acc, pop, hd;
    if (lock != 0) sel = lock;
    else if (data_req && !(pri && inst_req)) sel = 2;
    else if (inst_req) sel = 1;
    else sel = 0;
    e_req = ((sel == 1 && inst_req) || (sel == 2 && data_req)) && owners.size() < 4;
    acc = e_req && mem_addr_ok;
    pop = mem_data_ok && owners.size() > 0;
    hd  = pop ? owners[0] : 1'b0;
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
    chk("mem_addr", mem_addr, sel == 1 ? inst_addr : data_addr);
    chk("mem_wdata", mem_wdata, sel == 1 ? inst_wdata : data_wdata);
    chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
        sel == 1 ? {25'd0, inst_wr, inst_size, inst_wstrb} : {25'd0, data_wr, data_size, data_wstrb});
    chk("addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, acc && sel == 1, acc && sel == 2});
    chk("data_ok", {30'd0, inst_data_ok, data_data_ok}, {30'd0, pop && !hd, pop && hd});
    chk("rdata", inst_rdata ^ data_rdata ^ data_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("resp_err", {31'd0, resp_err}, {31'd0, err});
    if (mem_data_ok && owners.size() == 0) err = 1;
    if (pop) void'(owners.pop_front());
    if (acc) owners.push_back(sel == 2);
    if (acc) lock = 0; else if (e_req) lock = sel;
    if (acc && sel == 2 && inst_req) pri = 1;
    if (acc && sel == 1) pri = 0;
    last_iok = acc && sel == 1;
    last_dok = acc && sel == 2;
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drain();
    data_req = 0; inst_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < 8 && owners.size() > 0; i++) begin
      mem_data_ok = 1; mem_rdata = $urandom; #1 eval(); tick();
    end
    mem_data_ok = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    data_addr = 32'h1234_5678;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_payload", mem_addr, 32'h1234_5678);
    reset = 0;
    model_reset();
    tick();

    // single load
    data_req = 1; data_addr = 32'h1C00_0100; mem_addr_ok = 1;
    #1 eval();
    chk("load_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("load_mem_addr", mem_addr, 32'h1C00_0100);
    tick();
    data_req = 0; mem_addr_ok = 0;
    repeat (2) begin #1 eval(); tick(); end
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    #1 eval();
    chk("load_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd2);
    chk("load_rdata", data_rdata, 32'hDEAD_BEEF);
    tick();
    mem_data_ok = 0;

    // lock
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1 eval(); chk("lock_c0_addr", mem_addr, 32'hBFC0_0000); tick();
    data_req = 1; data_addr = 32'h1C00_0200;
    #1 eval(); chk("lock_c1_addr", mem_addr, 32'hBFC0_0000); tick();
    mem_addr_ok = 1;
    #1 eval(); chk("lock_c2_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2); tick();
    inst_req = 0;
    #1 eval(); chk("lock_c3_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    chk("lock_c3_addr", mem_addr, 32'h1C00_0200); tick();
    drain();

    // fairness: D,I,D,I,D,I
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 6; k++) begin
      mem_data_ok = (k > 0);
      #1 eval();
      chk("fair_grant", {30'd0, inst_addr_ok, data_addr_ok}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    drain();

    // full
    data_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1 eval(); chk("full_acc", {31'd0, data_addr_ok}, 32'd1); tick();
    end
    #1 eval(); chk("full_block", {31'd0, mem_req}, 32'd0); tick();
    mem_data_ok = 1;
    #1 eval(); chk("full_pop_cycle", {31'd0, mem_req}, 32'd0); tick();
    mem_data_ok = 0;
    #1 eval(); chk("full_reaccept", {31'd0, data_addr_ok}, 32'd1); tick();
    drain();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom; inst_wdata = $urandom;
        inst_wr = 0; inst_size = 2'($urandom_range(0, 2)); inst_wstrb = 4'($urandom);
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
      end
      mem_addr_ok = 1'($urandom);
      mem_data_ok = (owners.size() > 0) ? 1'($urandom) : ($urandom_range(0, 99) == 0);
      mem_rdata = $urandom;
      #1 eval();
      tick();
      if (last_iok) inst_req = 0;
      if (last_dok) data_req = 0;
    end
    drain();

    // error then asynchronous reset with outstanding requests
    reset = 1; #1 model_reset(); tick(); reset = 0; tick();
    mem_data_ok = 1;
    #1 eval(); chk("err_no_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0); tick();
    mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
    #1 eval(); chk("err_sticky", {31'd0, resp_err}, 32'd1); tick();
    #1 eval(); tick();
    #1 reset = 1;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_err", {31'd0, resp_err}, 32'd0);
    chk("async_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    model_reset();
    tick();
    reset = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1 eval(); chk("post_rst_empty", {30'd0, inst_data_ok, data_data_ok}, 32'd0); tick();
    mem_data_ok = 0;
    #1 eval(); chk("post_rst_err", {31'd0, resp_err}, 32'd1); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
